// File: rtl/text_console_ctrl_if.sv
// Byte-stream input and text-buffer write-port bundle of the text console controller.
// master = CPU-side producer / observer, slave = the console controller itself.
interface text_console_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              wctrl;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic [ADDR_W-1:0] cursor_addr;
  logic              busy;

  modport master (
    output char_valid, char_data,
    input  char_ready, wctrl, waddr, wdata, cursor_addr, busy
  );

  modport slave (
    input  char_valid, char_data,
    output char_ready, wctrl, waddr, wdata, cursor_addr, busy
  );
endinterface

// File: rtl/text_console_ctrl.sv
// VGA text console write sequencer: buffers CPU bytes, interprets control codes,
// tracks the cursor and drives the character buffer write port.
module text_console_ctrl #(
  parameter int         COLS       = 40,
  parameter int         ROWS       = 16,
  parameter int         COL_W      = 6,
  parameter int         ADDR_W     = 11,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BLANK      = 8'h00
) (
  input logic               clk,
  input logic               reset,
  text_console_ctrl_if.slave bus
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  localparam logic [7:0] CODE_NEWLINE   = 8'h0A;
  localparam logic [7:0] CODE_CLEAR     = 8'h0C;
  localparam logic [7:0] CODE_BACKSPACE = 8'h60;

  typedef enum logic [1:0] {IDLE, DISPATCH, CLEAR} state_t;

  state_t state, state_next;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;

  logic [7:0]       cmd;
  logic [ROW_W-1:0] row, row_next, clr_row, clr_row_next;
  logic [COL_W-1:0] col, col_next, clr_col, clr_col_next;
  logic             wctrl_q, wctrl_next;
  logic [ADDR_W-1:0] waddr_q, waddr_next;
  logic [7:0]       wdata_q, wdata_next;
  logic             printable, at_home, clear_last;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'({r, c});
  endfunction

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign push  = bus.char_valid && !full;
  assign pop   = (state == IDLE) && !empty;

  assign printable  = (cmd >= 8'h20) && (cmd <= 8'h7E) && (cmd != CODE_BACKSPACE);
  assign at_home    = (row == '0) && (col == '0);
  assign clear_last = (clr_row == LAST_ROW) && (clr_col == LAST_COL);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.char_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cmd    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cmd    <= fifo_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      clr_row <= '0;
      clr_col <= '0;
      wctrl_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_next;
      row     <= row_next;
      col     <= col_next;
      clr_row <= clr_row_next;
      clr_col <= clr_col_next;
      wctrl_q <= wctrl_next;
      waddr_q <= waddr_next;
      wdata_q <= wdata_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (!empty) state_next = DISPATCH;
      DISPATCH: state_next = (cmd == CODE_CLEAR) ? CLEAR : IDLE;
      CLEAR:    if (clear_last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Write port and cursor values to be registered at the end of this cycle.
  always_comb begin
    wctrl_next   = 1'b0;
    waddr_next   = waddr_q;
    wdata_next   = wdata_q;
    row_next     = row;
    col_next     = col;
    clr_row_next = clr_row;
    clr_col_next = clr_col;
    case (state)
      DISPATCH: begin
        if (printable) begin
          wctrl_next = 1'b1;
          waddr_next = cell_addr(row, col);
          wdata_next = cmd - 8'h20;
          if (col != LAST_COL) begin
            col_next = col + 1'b1;
          end else if (row != LAST_ROW) begin
            row_next = row + 1'b1;
            col_next = '0;
          end
        end else if (cmd == CODE_BACKSPACE) begin
          if (!at_home) begin
            if (col != '0) begin
              col_next = col - 1'b1;
            end else begin
              row_next = row - 1'b1;
              col_next = LAST_COL;
            end
            wctrl_next = 1'b1;
            waddr_next = cell_addr(row_next, col_next);
            wdata_next = BLANK;
          end
        end else if (cmd == CODE_NEWLINE) begin
          col_next = '0;
          if (row != LAST_ROW) row_next = row + 1'b1;
        end else if (cmd == CODE_CLEAR) begin
          clr_row_next = '0;
          clr_col_next = '0;
        end
      end
      CLEAR: begin
        wctrl_next = 1'b1;
        waddr_next = cell_addr(clr_row, clr_col);
        wdata_next = BLANK;
        if (clr_col != LAST_COL) begin
          clr_col_next = clr_col + 1'b1;
        end else begin
          clr_col_next = '0;
          clr_row_next = clr_row + 1'b1;
        end
        if (clear_last) begin
          row_next = '0;
          col_next = '0;
        end
      end
      default: ;
    endcase
  end

  assign bus.char_ready  = !full;
  assign bus.wctrl       = wctrl_q;
  assign bus.waddr       = waddr_q;
  assign bus.wdata       = wdata_q;
  assign bus.cursor_addr = cell_addr(row, col);
  assign bus.busy        = !empty || (state != IDLE);

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: a cursor model queues expected buffer
// writes as bytes are accepted; a negedge monitor pops and compares each write.
module tb_text_console_ctrl;

  localparam int COLS = 40;
  localparam int ROWS = 16;
  localparam int STRIDE = 64;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   mrow = 0;
  int   mcol = 0;
  wr_t  exp_q[$];

  text_console_ctrl_if #(.ADDR_W(11)) bus ();

  text_console_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int modelAddr();
    return mrow * STRIDE + mcol;
  endfunction

  // Reference behaviour of one accepted byte: queue its writes, move the model cursor.
  task automatic modelByte(input logic [7:0] b);
    wr_t w;
    if (b == 8'h0C) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          w.addr = 11'(r * STRIDE + c);
          w.data = 8'h00;
          exp_q.push_back(w);
        end
      mrow = 0;
      mcol = 0;
    end else if (b == 8'h60) begin
      if (mrow != 0 || mcol != 0) begin
        if (mcol > 0) mcol--;
        else begin
          mrow--;
          mcol = COLS - 1;
        end
        w.addr = 11'(modelAddr());
        w.data = 8'h00;
        exp_q.push_back(w);
      end
    end else if (b == 8'h0A) begin
      mcol = 0;
      if (mrow < ROWS - 1) mrow++;
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      w.addr = 11'(modelAddr());
      w.data = b - 8'h20;
      exp_q.push_back(w);
      if (mcol < COLS - 1) mcol++;
      else if (mrow < ROWS - 1) begin
        mrow++;
        mcol = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bit accepted = 0;
    @(negedge clk);
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    for (int i = 0; i < 3000; i++) begin
      if (bus.char_ready === 1'b1) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) begin
      modelByte(b);
      @(posedge clk);
      #1 bus.char_valid = 1'b0;
    end else begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      bus.char_valid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && bus.wctrl === 1'b0) begin
        done = 1;
        break;
      end
    end
    if (!done) checkOutput("idle_timeout", 32'd0, 32'd1);
    checkOutput("pending_writes", exp_q.size(), 32'd0);
    checkOutput("cursor_addr", bus.cursor_addr, modelAddr());
  endtask

  always @(negedge clk) begin
    if (bus.wctrl === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("write_pending", 32'd0, 32'd1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("waddr", bus.waddr, e.addr);
        checkOutput("wdata", bus.wdata, e.data);
      end
    end
  end

  initial begin
    int n;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_wctrl", bus.wctrl, 32'd0);
    checkOutput("rst_waddr", bus.waddr, 32'd0);
    checkOutput("rst_wdata", bus.wdata, 32'd0);
    checkOutput("rst_ready", bus.char_ready, 32'd1);
    checkOutput("rst_busy", bus.busy, 32'd0);
    checkOutput("rst_cursor", bus.cursor_addr, 32'd0);

    applyStimulus(8'h41);
    waitIdle();

    // Return to home, fill row 0, wrap, then backspace across the row boundary.
    applyStimulus(8'h60);
    for (int i = 0; i < COLS; i++) applyStimulus(8'h42);
    waitIdle();
    checkOutput("wrap_cursor", bus.cursor_addr, 32'd64);
    applyStimulus(8'h60);
    waitIdle();
    checkOutput("bs_cursor", bus.cursor_addr, 32'd39);

    // Walk to the last cell and saturate there.
    for (int i = 0; i < ROWS - 1; i++) applyStimulus(8'h0A);
    for (int i = 0; i < COLS - 1; i++) applyStimulus(8'h30 + 8'(i % 10));
    waitIdle();
    checkOutput("last_cell", bus.cursor_addr, 32'd999);
    applyStimulus(8'h43);
    applyStimulus(8'h44);
    waitIdle();
    checkOutput("saturate", bus.cursor_addr, 32'd999);
    applyStimulus(8'h0A);
    waitIdle();
    checkOutput("nl_last_row", bus.cursor_addr, 32'd960);

    // Full sweep must be one unbroken run of strobes.
    applyStimulus(8'h0C);
    n = 0;
    for (int i = 0; i < 50 && bus.wctrl !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 700 && bus.wctrl === 1'b1; i++) begin
      n++;
      @(negedge clk);
    end
    checkOutput("clear_run", n, 32'd640);
    waitIdle();
    applyStimulus(8'h60);
    waitIdle();

    // Abort a sweep with reset after 100 cells.
    applyStimulus(8'h0C);
    n = 0;
    for (int i = 0; i < 300 && n < 100; i++) begin
      @(negedge clk);
      if (bus.wctrl === 1'b1) n++;
    end
    checkOutput("sweep_100", n, 32'd100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    mrow = 0;
    mcol = 0;
    @(negedge clk);
    checkOutput("abort_wctrl", bus.wctrl, 32'd0);
    checkOutput("abort_cursor", bus.cursor_addr, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Burst into the FIFO while a sweep holds the FSM.
    applyStimulus(8'h0C);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) applyStimulus(8'h31 + 8'(i));
    @(negedge clk);
    checkOutput("ready_full", bus.char_ready, 32'd0);
    checkOutput("busy_clear", bus.busy, 32'd1);
    applyStimulus(8'h35);
    applyStimulus(8'h36);
    waitIdle();
    checkOutput("burst_cursor", bus.cursor_addr, 32'd6);

    // Non-printable, non-control codes are discarded.
    applyStimulus(8'h07);
    applyStimulus(8'h7F);
    waitIdle();
    checkOutput("discard_busy", bus.busy, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
